// File: rtl/portgroup_rxq.sv
// Receive queue for the regf port group: valid/ready stream into a
// circular FIFO, head/level/overflow exposed as bus read values.
module portgroup_rxq #(
  parameter int width_p  = 8,
  parameter int depth_p  = 4,
  parameter int thresh_p = 2
) (
  input  logic                         main_clk_i,
  input  logic                         main_rst_i,
  input  logic                         rx_valid_i,
  input  logic [width_p-1:0]           rx_data_i,
  output logic                         rx_ready_o,
  input  logic                         regf_ctrl_ena_rval_i,
  input  logic                         regf_ctrl_mode_rval_i,
  input  logic                         regf_ctrl_flush_wr_i,
  output logic [width_p-1:0]           regf_rx_data_rbus_o,
  input  logic                         regf_rx_data_rd_i,
  output logic [$clog2(depth_p+1)-1:0] regf_rx_level_rbus_o,
  output logic [7:0]                   regf_rx_ovf_rbus_o,
  input  logic                         regf_rx_ovf_rd_i,
  output logic                         irq_o
);

  localparam int lvl_w = $clog2(depth_p + 1);
  localparam int ptr_w = $clog2(depth_p);
  localparam logic [ptr_w-1:0] ptr_last = ptr_w'(depth_p - 1);
  localparam logic [lvl_w-1:0] lvl_full = lvl_w'(depth_p);
  localparam logic [lvl_w-1:0] lvl_thr  = lvl_w'(thresh_p);

  logic [width_p-1:0] mem_q [depth_p];
  logic [ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
  logic [lvl_w-1:0]   level_q, level_d;
  logic [7:0]         ovf_q, ovf_d;
  logic               irq_q, irq_d;

  logic full, empty, hs, push, pop, drop;

  // Ready uses only registered state plus the control read values.
  always_comb begin
    full  = (level_q == lvl_full);
    empty = (level_q == '0);
    rx_ready_o = regf_ctrl_ena_rval_i & ~main_rst_i &
                 (regf_ctrl_mode_rval_i | ~full);
    hs   = rx_valid_i & rx_ready_o;
    pop  = regf_rx_data_rd_i & ~empty & ~regf_ctrl_flush_wr_i;
    push = hs & ~regf_ctrl_flush_wr_i & (~full | pop);
    drop = hs & ~regf_ctrl_flush_wr_i & full & ~pop;
  end

  // Next-state for pointers, level, overflow counter and interrupt.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    irq_d    = (level_q >= lvl_thr);
    if (regf_ctrl_flush_wr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push)
        wr_ptr_d = (wr_ptr_q == ptr_last) ? '0 : wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_d = (rd_ptr_q == ptr_last) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)
        level_d = level_q + 1'b1;
      else if (pop && !push)
        level_d = level_q - 1'b1;
    end
    if (regf_rx_ovf_rd_i)
      ovf_d = drop ? 8'd1 : 8'd0;
    else if (drop && ovf_q != 8'hff)
      ovf_d = ovf_q + 8'd1;
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge main_clk_i) begin
    if (main_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
    end
  end

  // Storage array; contents are masked by the level so need no reset.
  always_ff @(posedge main_clk_i) begin
    if (push)
      mem_q[wr_ptr_q] <= rx_data_i;
  end

  // Bus read values; head reads as zero when the queue is empty.
  always_comb begin
    regf_rx_data_rbus_o  = empty ? '0 : mem_q[rd_ptr_q];
    regf_rx_level_rbus_o = level_q;
    regf_rx_ovf_rbus_o   = ovf_q;
    irq_o                = irq_q;
  end

endmodule

// File: tb/tb_portgroup_rxq.sv
// Self-checking bench for portgroup_rxq: directed test plan plus
// randomized traffic against a queue-based reference model.
module tb_portgroup_rxq;

  localparam int DEPTH = 4;
  localparam int THR   = 2;

  logic       clk = 1'b0;
  logic       rst, ena, mode, flush;
  logic       rx_valid, rx_ready, data_rd, ovf_rd, irq;
  logic [7:0] rx_data, data_bus, ovf;
  logic [2:0] lvl;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  int         movf;
  bit         mirq;
  logic [7:0] last_rd;

  always #5 clk = ~clk;

  portgroup_rxq #(.width_p(8), .depth_p(DEPTH), .thresh_p(THR)) dut (
    .main_clk_i            (clk),
    .main_rst_i            (rst),
    .rx_valid_i            (rx_valid),
    .rx_data_i             (rx_data),
    .rx_ready_o            (rx_ready),
    .regf_ctrl_ena_rval_i  (ena),
    .regf_ctrl_mode_rval_i (mode),
    .regf_ctrl_flush_wr_i  (flush),
    .regf_rx_data_rbus_o   (data_bus),
    .regf_rx_data_rd_i     (data_rd),
    .regf_rx_level_rbus_o  (lvl),
    .regf_rx_ovf_rbus_o    (ovf),
    .regf_rx_ovf_rd_i      (ovf_rd),
    .irq_o                 (irq)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, compare outputs with the model, then
  // advance the model by the queue rules and step past the edge.
  task automatic tick(input bit v, input logic [7:0] d, input bit rd,
                      input bit orr, input bit fl);
    bit rdy, hs, popped, was_full, dropped;
    logic [7:0] head;
    rx_valid = v; rx_data = d; data_rd = rd; ovf_rd = orr; flush = fl;
    #1;
    rdy  = !rst && ena && (mode || mq.size() < DEPTH);
    head = (mq.size() > 0) ? mq[0] : 8'h00;
    check("ready", rx_ready, rdy);
    check("data", data_bus, head);
    check("level", lvl, mq.size());
    check("ovf", ovf, movf);
    check("irq", irq, mirq);
    if (rd) last_rd = data_bus;
    if (rst) begin
      mq.delete(); movf = 0; mirq = 0;
    end else begin
      hs      = v && rdy;
      mirq    = (mq.size() >= THR);
      dropped = 0;
      if (fl) begin
        mq.delete();
      end else begin
        was_full = (mq.size() == DEPTH);
        popped   = rd && mq.size() > 0;
        if (popped) void'(mq.pop_front());
        if (hs) begin
          if (!was_full || popped) mq.push_back(d);
          else dropped = 1;
        end
      end
      if (orr) movf = dropped ? 1 : 0;
      else if (dropped && movf < 255) movf++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_rd [7];
    exp_rd = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h00};
    rst = 1; ena = 1; mode = 0; flush = 0;
    rx_valid = 0; rx_data = 0; data_rd = 0; ovf_rd = 0;
    last_rd = 0; movf = 0; mirq = 0;
    @(posedge clk); #1;

    // reset and idle
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    rst = 0;
    tick(0, 0, 0, 0, 0);
    check("idle_rdy", rx_ready, 1'b1);

    // fill / backpressure
    tick(1, 8'h11, 0, 0, 0);
    tick(1, 8'h22, 0, 0, 0);
    tick(1, 8'h33, 0, 0, 0);
    tick(1, 8'h44, 0, 0, 0);
    tick(1, 8'h55, 0, 0, 0);
    tick(1, 8'h55, 0, 0, 0);
    check("fill_lvl", lvl, 3'd4);
    check("fill_head", data_bus, 8'h11);
    check("fill_rdy", rx_ready, 1'b0);
    check("fill_irq", irq, 1'b1);

    // drain with interleaved pushes, pointers wrap
    for (int i = 0; i < 7; i++) begin
      if (i < 2) tick(1, 8'h55, 1, 0, 0);
      else if (i == 2) tick(1, 8'h66, 1, 0, 0);
      else tick(0, 0, 1, 0, 0);
      check($sformatf("rd%0d", i), last_rd, exp_rd[i]);
    end
    check("drain_lvl", lvl, 3'd0);

    // drop mode overflow
    mode = 1;
    for (int i = 0; i < 4; i++) tick(1, 8'ha1 + 8'(i), 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(1, 8'hb1 + 8'(i), 0, 0, 0);
    check("drop_ovf3", ovf, 8'd3);
    check("drop_head", data_bus, 8'ha1);
    check("drop_lvl", lvl, 3'd4);
    tick(1, 8'hc4, 1, 0, 0);
    check("swap_lvl", lvl, 3'd4);
    check("swap_head", data_bus, 8'ha2);
    check("swap_ovf", ovf, 8'd3);
    for (int i = 0; i < 260; i++) tick(1, 8'(i), 0, 0, 0);
    check("ovf_sat", ovf, 8'hff);
    tick(1, 8'h5a, 0, 1, 0);
    check("ovf_clr_drop", ovf, 8'd1);

    // flush collision
    mode = 0;
    tick(0, 0, 0, 0, 1);
    tick(1, 8'h71, 0, 0, 0);
    tick(1, 8'h72, 0, 0, 0);
    tick(1, 8'h73, 0, 0, 0);
    tick(1, 8'h77, 1, 0, 1);
    check("fl_lvl", lvl, 3'd0);
    check("fl_data", data_bus, 8'h00);
    check("fl_ovf", ovf, 8'd1);
    tick(0, 0, 0, 0, 0);
    check("fl_irq", irq, 1'b0);

    // enable off
    tick(1, 8'h81, 0, 0, 0);
    tick(1, 8'h82, 0, 0, 0);
    ena = 0;
    tick(1, 8'h83, 0, 0, 0);
    check("dis_rdy", rx_ready, 1'b0);
    check("dis_lvl", lvl, 3'd2);
    tick(1, 8'h83, 1, 0, 0);
    check("dis_rd0", last_rd, 8'h81);
    tick(1, 8'h83, 1, 0, 0);
    check("dis_rd1", last_rd, 8'h82);
    check("dis_empty", lvl, 3'd0);
    ena = 1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      ena = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      tick($urandom_range(0, 3) != 0, 8'($urandom),
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 39) == 0);
    end
    rst = 0;
    tick(0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
